// File: rtl/ar_split_engine.sv
// ar_split_engine: rescales wide-master AXI read bursts to the narrow slave beat size and
// splits them into legal slave bursts, pushing one repacker descriptor per slave burst.
module ar_split_engine #(
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 3,
    parameter int LEN_WIDTH     = 8,
    parameter int M_DATA_WIDTH  = 128,
    parameter int S_DATA_WIDTH  = 32,
    parameter int MAX_BURST_LEN = 256,
    parameter int RL_WIDTH      = $clog2(M_DATA_WIDTH / S_DATA_WIDTH) + 1,
    parameter int XFER_WIDTH    = ID_WIDTH + RL_WIDTH + LEN_WIDTH + 1
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic [ID_WIDTH-1:0]   m_arid,
    input  logic [ADDR_WIDTH-1:0] m_araddr,
    input  logic [LEN_WIDTH-1:0]  m_arlen,
    input  logic [2:0]            m_arsize,
    input  logic [1:0]            m_arburst,
    input  logic                  m_arvalid,
    output logic                  m_arready,
    output logic [ID_WIDTH-1:0]   s_arid,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [LEN_WIDTH-1:0]  s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic                  xfer_full,
    output logic                  xfer_valid,
    output logic [XFER_WIDTH-1:0] xfer_data
);
    localparam int S_SZ  = $clog2(S_DATA_WIDTH / 8);
    localparam int M_SZ  = $clog2(M_DATA_WIDTH / 8);
    localparam int CNT_W = LEN_WIDTH + RL_WIDTH + 1;
    localparam int BW    = (CNT_W > 13) ? CNT_W : 13;
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST_LEN);
    localparam logic [1:0] B_FIXED = 2'd0;
    localparam logic [1:0] B_INCR  = 2'd1;
    localparam logic [1:0] B_WRAP  = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_ISSUE} state_t;

    state_t state_q, state_d;

    logic                  arready_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            sz_q, osz_q;
    logic [RL_WIDTH-1:0]   rl_q;
    logic [1:0]            burst_q;
    logic [CNT_W-1:0]      total_q, rem_q, beats_q;
    logic                  first_q;

    logic [ID_WIDTH-1:0]   s_arid_q;
    logic [ADDR_WIDTH-1:0] s_araddr_q;
    logic [LEN_WIDTH-1:0]  s_arlen_q;
    logic [2:0]            s_arsize_q;
    logic [1:0]            s_arburst_q;
    logic                  s_arvalid_q;
    logic                  last_q;

    logic m_hs, s_hs;

    function automatic logic [BW-1:0] min2(input logic [BW-1:0] a, input logic [BW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic is_wrap_len(input logic [BW-1:0] n);
        return (n == BW'(2)) || (n == BW'(4)) || (n == BW'(8)) || (n == BW'(16));
    endfunction

    assign m_hs = m_arvalid & arready_q;
    assign s_hs = s_arvalid_q & s_arready;

    // Size clamping and beat rescaling of the incoming master request
    logic [2:0]          sz_c, osz_c;
    logic [RL_WIDTH-1:0] rl_c;
    logic [CNT_W-1:0]    total_c;

    always_comb begin
        sz_c    = (m_arsize > 3'(M_SZ)) ? 3'(M_SZ) : m_arsize;
        osz_c   = (sz_c > 3'(S_SZ)) ? 3'(S_SZ) : sz_c;
        rl_c    = RL_WIDTH'(sz_c - osz_c);
        total_c = (CNT_W'(m_arlen) + CNT_W'(1)) << rl_c;
    end

    // Next sub-burst selection
    logic [ADDR_WIDTH-1:0] a_mask, a_align, sz_mask, win, base, calc_addr;
    logic [BW-1:0]         rem_w, lim_4k, wrap_first, calc_beats;
    logic [1:0]            calc_burst;

    always_comb begin
        a_mask     = ~((ADDR_WIDTH'(1) << osz_q) - ADDR_WIDTH'(1));
        a_align    = addr_q & a_mask;
        sz_mask    = ~((ADDR_WIDTH'(1) << sz_q) - ADDR_WIDTH'(1));
        win        = ADDR_WIDTH'(total_q) << osz_q;
        base       = addr_q & ~(win - ADDR_WIDTH'(1));
        rem_w      = BW'(rem_q);
        lim_4k     = (BW'(4096) - BW'(a_align[11:0])) >> osz_q;
        wrap_first = BW'((win - (a_align - base)) >> osz_q);
        calc_addr  = addr_q;
        calc_beats = min2(rem_w, MAX_B);
        calc_burst = B_INCR;
        case (burst_q)
            B_FIXED: begin
                if (rl_q == '0) begin
                    calc_burst = B_FIXED;
                end else begin
                    calc_addr  = addr_q & sz_mask;
                    calc_beats = BW'(1) << rl_q;
                end
            end
            // Only an unscaled WRAP of a legal length passes through; rescaled ones become INCR pieces
            B_WRAP: begin
                if (rl_q == '0 && is_wrap_len(rem_w)) begin
                    calc_beats = rem_w;
                    calc_burst = B_WRAP;
                end else if (first_q) begin
                    calc_beats = min2(rem_w, wrap_first);
                end else begin
                    calc_addr  = base;
                    calc_beats = rem_w;
                end
            end
            default: calc_beats = min2(calc_beats, lim_4k);
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (m_hs) state_d = ST_CALC;
            ST_CALC:  if (!xfer_full) state_d = ST_ISSUE;
            ST_ISSUE: if (s_hs) state_d = (rem_q == beats_q) ? ST_IDLE : ST_CALC;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            arready_q   <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            sz_q        <= '0;
            osz_q       <= '0;
            rl_q        <= '0;
            burst_q     <= '0;
            total_q     <= '0;
            rem_q       <= '0;
            beats_q     <= '0;
            first_q     <= 1'b0;
            s_arid_q    <= '0;
            s_araddr_q  <= '0;
            s_arlen_q   <= '0;
            s_arsize_q  <= '0;
            s_arburst_q <= '0;
            s_arvalid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            arready_q   <= (state_d == ST_IDLE);
            s_arvalid_q <= (state_d == ST_ISSUE);
            if (m_hs) begin
                id_q    <= m_arid;
                addr_q  <= m_araddr;
                sz_q    <= sz_c;
                osz_q   <= osz_c;
                rl_q    <= rl_c;
                burst_q <= m_arburst;
                total_q <= total_c;
                rem_q   <= total_c;
                first_q <= 1'b1;
            end
            if (state_q == ST_CALC) begin
                s_arid_q    <= id_q;
                s_araddr_q  <= calc_addr;
                s_arlen_q   <= LEN_WIDTH'(calc_beats - BW'(1));
                s_arsize_q  <= osz_q;
                s_arburst_q <= calc_burst;
                beats_q     <= CNT_W'(calc_beats);
                last_q      <= (rem_w == calc_beats);
            end
            if (s_hs) begin
                rem_q   <= rem_q - beats_q;
                first_q <= 1'b0;
                // INCR continues from the aligned start of the piece just issued
                if (burst_q != B_FIXED && burst_q != B_WRAP)
                    addr_q <= (s_araddr_q & a_mask) + (ADDR_WIDTH'(beats_q) << osz_q);
            end
        end
    end

    assign m_arready  = arready_q;
    assign s_arid     = s_arid_q;
    assign s_araddr   = s_araddr_q;
    assign s_arlen    = s_arlen_q;
    assign s_arsize   = s_arsize_q;
    assign s_arburst  = s_arburst_q;
    assign s_arvalid  = s_arvalid_q;
    assign xfer_valid = s_hs;
    assign xfer_data  = {s_arid_q, rl_q, s_arlen_q, last_q};

endmodule

// File: tb/tb_ar_split_engine.sv
// tb_ar_split_engine: directed and randomized AR bursts checked against a burst-level model.
module tb_ar_split_engine;
    logic        clk;
    logic        arst;
    logic [2:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [2:0]  s_arid;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic        xfer_full;
    logic        xfer_valid;
    logic [14:0] xfer_data;

    ar_split_engine dut (
        .aclk(clk), .arst(arst),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .xfer_full(xfer_full), .xfer_valid(xfer_valid), .xfer_data(xfer_data)
    );

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  rl;
        logic        last;
    } sb_t;

    sb_t model_q[$];
    sb_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    bit  rdy_mode = 0, rdy_force = 0, full_mode = 0, full_force = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] id, input logic [31:0] a, input int n, input int os,
                        input int bt, input int rl, input bit last);
        sb_t e;
        e.id = id; e.addr = a; e.len = 8'(n - 1); e.size = 3'(os);
        e.burst = 2'(bt); e.rl = 3'(rl); e.last = last;
        model_q.push_back(e);
    endtask

    // Whole master burst -> ordered list of slave bursts, worked out in bytes and beats
    task automatic model(input logic [2:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
        int sz, rl, os, tot, bytes, left, n, room;
        logic [31:0] a, al, base, win;
        sz = (size > 4) ? 4 : size;
        rl = (sz > 2) ? sz - 2 : 0;
        os = (sz > 2) ? 2 : sz;
        tot = (len + 1) << rl;
        bytes = 1 << os;
        model_q.delete();
        if (burst == 0 && rl > 0) begin
            for (int k = 0; k <= len; k++)
                push(id, addr - addr % (32'd1 << sz), 1 << rl, os, 1, rl, k == len);
        end else if (burst == 0) begin
            left = tot;
            while (left > 0) begin
                n = (left > 256) ? 256 : left;
                push(id, addr, n, os, 0, rl, left == n);
                left -= n;
            end
        end else if (burst == 2 && rl == 0 && (tot inside {2, 4, 8, 16})) begin
            push(id, addr, tot, os, 2, rl, 1'b1);
        end else if (burst == 2) begin
            win  = 32'(tot * bytes);
            base = addr - addr % win;
            al   = addr - addr % 32'(bytes);
            n    = int'((base + win - al) / 32'(bytes));
            push(id, addr, n, os, 1, rl, n == tot);
            if (n < tot) push(id, base, tot - n, os, 1, rl, 1'b1);
        end else begin
            a = addr;
            left = tot;
            while (left > 0) begin
                al = a - a % 32'(bytes);
                room = int'((32'd4096 - al % 32'd4096) / 32'(bytes));
                n = left;
                if (n > 256) n = 256;
                if (n > room) n = room;
                push(id, a, n, os, 1, rl, left == n);
                a = al + 32'(n * bytes);
                left -= n;
            end
        end
    endtask

    task automatic pin(input int idx, input logic [31:0] a, input int len, input int bt,
                       input int rl, input bit last);
        sb_t e;
        e = (idx < model_q.size()) ? model_q[idx] : '0;
        check("model_pin", 64'({e.addr, e.len, e.size, e.burst, e.rl, e.last}),
              64'({a, 8'(len), 3'd2, 2'(bt), 3'(rl), last}));
    endtask

    task automatic send(input logic [2:0] id, input logic [31:0] addr, input int len,
                        input int size, input int burst);
        int n;
        n = 0;
        @(posedge clk); #1;
        m_arid = id; m_araddr = addr; m_arlen = 8'(len); m_arsize = 3'(size);
        m_arburst = 2'(burst); m_arvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (m_arready) break;
            n++;
            if (n > 200) begin
                check("arready_timeout", 64'(m_arready), 64'(1));
                break;
            end
        end
        @(posedge clk); #1;
        m_arvalid = 1'b0;
        @(negedge clk);
        check("post_accept", 64'({m_arready, s_arvalid}), 64'(0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 || !m_arready) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                check("done_timeout", 64'(exp_q.size()), 64'(0));
                break;
            end
        end
    endtask

    task automatic issue(input logic [2:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
        model(id, addr, len, size, burst);
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        send(id, addr, len, size, burst);
        wait_done();
    endtask

    initial begin
        s_arready = 0;
        xfer_full = 0;
        forever begin
            @(posedge clk); #1;
            s_arready = rdy_mode ? rdy_force : ($urandom_range(0, 9) < 6);
            xfer_full = full_mode ? full_force : ($urandom_range(0, 9) < 2);
        end
    end

    // Per-cycle compare: handshake contents, descriptor strobe, and hold while stalled
    logic        prev_wait = 0;
    logic [47:0] prev_ar = '0;
    always @(negedge clk) begin
        sb_t e;
        if (arst) begin
            prev_wait = 0;
        end else begin
            check("xfer_valid", 64'(xfer_valid), 64'(s_arvalid && s_arready));
            if (prev_wait)
                check("ar_hold", 64'({s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst}),
                      64'({1'b1, prev_ar}));
            if (s_arvalid && s_arready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_burst", 64'(s_araddr), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("s_ar", 64'({s_arid, s_araddr, s_arlen, s_arsize, s_arburst}),
                          64'({e.id, e.addr, e.len, e.size, e.burst}));
                    check("xfer_data", 64'(xfer_data), 64'({e.id, e.rl, e.len, e.last}));
                end
            end
            prev_wait = s_arvalid && !s_arready;
            prev_ar = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst};
        end
    end

    initial begin
        logic [31:0] a;
        int bt, ln, sz, n;
        arst = 1; m_arvalid = 0; m_arid = 0; m_araddr = 0; m_arlen = 0; m_arsize = 0; m_arburst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ar", 64'({s_arid, s_araddr, s_arlen, s_arsize, s_arburst}), 64'(0));
        check("rst_ctl", 64'({m_arready, s_arvalid, xfer_valid, xfer_data}), 64'(0));
        @(posedge clk); #3;
        arst = 0;
        @(negedge clk);
        check("arready_after_release", 64'(m_arready), 64'(0));
        @(negedge clk);
        check("arready_rises", 64'(m_arready), 64'(1));

        model(3'd1, 32'h100, 3, 4, 1);
        check("model_n1", 64'(model_q.size()), 64'(1));
        pin(0, 32'h100, 15, 1, 2, 1);
        issue(3'd1, 32'h100, 3, 4, 1);

        model(3'd2, 32'h0, 127, 4, 1);
        check("model_n2", 64'(model_q.size()), 64'(2));
        pin(0, 32'h000, 255, 1, 2, 0);
        pin(1, 32'h400, 255, 1, 2, 1);
        issue(3'd2, 32'h0, 127, 4, 1);

        model(3'd3, 32'hFF8, 15, 2, 1);
        check("model_n3", 64'(model_q.size()), 64'(2));
        pin(0, 32'hFF8, 1, 1, 0, 0);
        pin(1, 32'h1000, 13, 1, 0, 1);
        issue(3'd3, 32'hFF8, 15, 2, 1);

        model(3'd4, 32'h130, 3, 4, 2);
        check("model_n4", 64'(model_q.size()), 64'(2));
        pin(0, 32'h130, 3, 1, 2, 0);
        pin(1, 32'h100, 11, 1, 2, 1);
        issue(3'd4, 32'h130, 3, 4, 2);

        model(3'd5, 32'h40, 1, 3, 0);
        check("model_n5", 64'(model_q.size()), 64'(2));
        pin(0, 32'h40, 1, 1, 1, 0);
        pin(1, 32'h40, 1, 1, 1, 1);
        issue(3'd5, 32'h40, 1, 3, 0);

        issue(3'd6, 32'h20, 3, 2, 2);
        issue(3'd7, 32'h1234, 2, 7, 0);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:8] = 4'hF;
            bt = int'($urandom_range(0, 2));
            sz = int'($urandom_range(0, 7));
            if (bt == 2) begin
                n = int'($urandom_range(0, 3));
                ln = (2 << n) - 1;
            end else if (bt == 0) begin
                ln = int'($urandom_range(0, 15));
            end else begin
                ln = ($urandom_range(0, 7) == 0) ? int'($urandom_range(128, 255))
                                                 : int'($urandom_range(0, 63));
            end
            issue(3'($urandom_range(0, 7)), a, ln, sz, bt);
        end

        full_mode = 1; full_force = 1; rdy_mode = 1; rdy_force = 1;
        repeat (2) @(posedge clk);
        model(3'd2, 32'h200, 0, 2, 1);
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        send(3'd2, 32'h200, 0, 2, 1);
        repeat (5) begin
            @(negedge clk);
            check("full_hold", 64'(s_arvalid), 64'(0));
        end
        full_force = 0; rdy_force = 0;
        n = 0;
        while (!s_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_after_full", 64'(s_arvalid), 64'(1));
        @(posedge clk); #3;
        arst = 1;
        exp_q.delete();
        #1;
        check("midrst_ar", 64'({s_arid, s_araddr, s_arlen, s_arsize, s_arburst}), 64'(0));
        check("midrst_ctl", 64'({m_arready, s_arvalid, xfer_valid, xfer_data}), 64'(0));
        @(posedge clk); #3;
        arst = 0;
        @(negedge clk);
        check("midrst_arready_low", 64'(m_arready), 64'(0));
        @(negedge clk);
        check("midrst_arready_high", 64'(m_arready), 64'(1));
        rdy_mode = 0; full_mode = 0;
        issue(3'd6, 32'h3F0, 7, 3, 1);
        issue(3'd1, 32'h80, 1, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
